systolic_feeder: RTL

Operand feeder sitting directly upstream of the N×N systolic array of `MAC` processing elements. It buffers an N×K matrix A and a K×N matrix B written over a simple port, clears the array, then streams A rows into the left edge and B columns into the top edge with the diagonal skew the array needs. It pulses `done` once every PE's `sum` holds its element of C = A·B.

---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_feeder_operand_bank.sv | 38 +++
 rtl/systolic_feeder.sv | 138 +++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array operand feeder.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLR    = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam int DEF_N = 2;
  localparam int DEF_K = 4;
  localparam int DEF_W = 4;
  localparam int ACC_W = 10;

  // Beat counter width: must hold K+N-2 (last stream beat) and N-2 (last drain beat).
  function automatic int beat_cnt_w(input int n, input int k);
    int max_v;
    max_v = k + n - 2;
    return (max_v < 2) ? 1 : $clog2(max_v + 1);
  endfunction

endpackage

// File: rtl/systolic_feeder_operand_bank.sv
// Operand register file: N*K entries of W bits, one write port, N combinational read ports.
// Contents are deliberately not reset so matrices persist across runs and resets.
module operand_bank #(
  parameter int N  = 2,
  parameter int K  = 4,
  parameter int W  = 4,
  parameter int AW = 3
) (
  input  logic            clk,
  input  logic            wr_en_i,
  input  logic [AW-1:0]   wr_addr_i,
  input  logic [W-1:0]    wr_data_i,
  input  logic [N*AW-1:0] rd_addr_i,
  output logic [N*W-1:0]  rd_data_o
);

  localparam int DEPTH = N * K;

  logic [W-1:0] mem_q [DEPTH];

  // Write port; addresses past the last entry are dropped.
  always_ff @(posedge clk) begin
    if (wr_en_i && (int'(wr_addr_i) < DEPTH)) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Parallel read ports; an out-of-range address reads as zero.
  always_comb begin
    rd_data_o = '0;
    for (int i = 0; i < N; i++) begin
      if (int'(rd_addr_i[i*AW +: AW]) < DEPTH) begin
        rd_data_o[i*W +: W] = mem_q[rd_addr_i[i*AW +: AW]];
      end
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand feeder for an NxN systolic MAC array: buffers A (NxK) and B (KxN),
// clears the array, streams skewed rows/columns, then pulses done.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int K = DEF_K,
  parameter int W = DEF_W,
  localparam int AW = (N * K > 1) ? $clog2(N * K) : 1
) (
  input  logic           clk,
  input  logic           res,
  input  logic           wr_en,
  input  logic           wr_sel,
  input  logic [AW-1:0]  wr_addr,
  input  logic [W-1:0]   wr_data,
  input  logic           start,
  output logic           busy,
  output logic           done,
  output logic           mac_clr,
  output logic [N*W-1:0] a_out,
  output logic [N*W-1:0] b_out,
  output state_t         dbg_state
);

  localparam int TW         = beat_cnt_w(N, K);
  localparam int LAST_BEAT  = K + N - 2;
  localparam int LAST_DRAIN = N - 2;

  state_t         state_q, state_d;
  logic [TW-1:0]  t_q, t_d;
  logic [N*W-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
  logic           busy_q, busy_d, done_q, done_d, mac_clr_q, mac_clr_d;

  logic           wr_ok;
  logic [N-1:0]   lane_ok;
  logic [N*AW-1:0] a_rd_addr, b_rd_addr;
  logic [N*W-1:0] a_rd_data, b_rd_data;

  // Writes land only while idle; sel picks the bank.
  assign wr_ok = wr_en && (state_q == IDLE);

  operand_bank #(.N(N), .K(K), .W(W), .AW(AW)) u_bank_a (
    .clk       (clk),
    .wr_en_i   (wr_ok && !wr_sel),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (a_rd_addr),
    .rd_data_o (a_rd_data)
  );

  operand_bank #(.N(N), .K(K), .W(W), .AW(AW)) u_bank_b (
    .clk       (clk),
    .wr_en_i   (wr_ok && wr_sel),
    .wr_addr_i (wr_addr),
    .wr_data_i (wr_data),
    .rd_addr_i (b_rd_addr),
    .rd_data_o (b_rd_data)
  );

  // Next state and beat counter; the counter is reused for the drain beats.
  always_comb begin
    state_d = state_q;
    t_d     = '0;
    unique case (state_q)
      IDLE:    if (start) state_d = CLR;
      CLR:     state_d = STREAM;
      STREAM: begin
        if (int'(t_q) >= LAST_BEAT) state_d = (N > 1) ? DRAIN : DONE;
        else                        t_d     = t_q + TW'(1);
      end
      DRAIN: begin
        if (int'(t_q) >= LAST_DRAIN) state_d = DONE;
        else                         t_d     = t_q + TW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Skewed read addresses for the beat about to be shown: lane i carries inner index t-i.
  always_comb begin
    lane_ok   = '0;
    a_rd_addr = '0;
    b_rd_addr = '0;
    for (int i = 0; i < N; i++) begin
      if ((int'(t_d) >= i) && ((int'(t_d) - i) < K)) begin
        lane_ok[i]            = 1'b1;
        a_rd_addr[i*AW +: AW] = AW'(i * K + int'(t_d) - i);
        b_rd_addr[i*AW +: AW] = AW'((int'(t_d) - i) * N + i);
      end
    end
  end

  // Output values for the coming cycle, decoded from the next state so outputs are registered.
  always_comb begin
    busy_d    = (state_d == CLR) || (state_d == STREAM) || (state_d == DRAIN);
    done_d    = (state_d == DONE);
    mac_clr_d = (state_d == CLR);
    a_out_d   = '0;
    b_out_d   = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_d == STREAM) && lane_ok[i]) begin
        a_out_d[i*W +: W] = a_rd_data[i*W +: W];
        b_out_d[i*W +: W] = b_rd_data[i*W +: W];
      end
    end
  end

  // State and output registers; reset aborts any run without a done or clear pulse.
  always_ff @(posedge clk) begin
    if (!res) begin
      state_q   <= IDLE;
      t_q       <= '0;
      a_out_q   <= '0;
      b_out_q   <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      a_out_q   <= a_out_d;
      b_out_q   <= b_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mac_clr_q <= mac_clr_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign mac_clr   = mac_clr_q;
  assign a_out     = a_out_q;
  assign b_out     = b_out_q;
  assign dbg_state = state_q;

endmodule
